// File: rtl/tlul_pkg.sv
// -----------------------------------------------------------------------------
// tlul_pkg
// TL-UL channel types, opcodes and field widths shared by the LSU host bridge
// and its neighbours, plus small width helpers for the bridge's counters.
// No ports (package).
// -----------------------------------------------------------------------------
package tlul_pkg;

    localparam int TL_AW  = 32;   // address width
    localparam int TL_DW  = 32;   // data width
    localparam int TL_DBW = 4;    // byte-enable width
    localparam int TL_SZW = 2;    // size field width
    localparam int TL_AIW = 8;    // source ID width on the bus
    localparam int TL_DIW = 1;    // sink ID width
    localparam int TL_AUW = 16;   // A-channel user width
    localparam int TL_DUW = 16;   // D-channel user width

    // Widest source ID the LSU bridge ever drives (MaxOutstanding <= 8).
    localparam int BrqTlulSrcW = 3;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic [TL_AUW-1:0]   a_user;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic [TL_DUW-1:0]   d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

    // Bits needed to count 0..max_out inclusive.
    function automatic int brq_cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    // Bits needed for a pointer over 0..max_out-1 (at least one bit).
    function automatic int brq_ptr_w(input int max_out);
        return (max_out > 1) ? $clog2(max_out) : 1;
    endfunction

endpackage

// File: rtl/brq_lsu_tlul_host.sv
// -----------------------------------------------------------------------------
// brq_lsu_tlul_host
// Bridges the core LSU request/grant interface onto a TL-UL host port.
// A-channel requests go out combinationally; up to MaxOutstanding transactions
// are tracked with rolling source IDs and D responses are checked in order and
// returned through a registered rvalid/rdata/err stage.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i/gnt_o           core request valid / accepted this cycle
//   we_i, be_i, addr_i,   store flag, byte enables, byte address,
//   wdata_i               store data
//   rvalid_o, rdata_o,    one-cycle response pulse, load data (0 for stores),
//   err_o                 response error
//   tl_o / tl_i           TL-UL host-to-device / device-to-host channels
//
// Optional feature macro: BRQ_TLUL_MISALIGN_ERR_EN
//   When defined, word-misaligned requests are never issued on TL-UL; they
//   wait for an idle bus, are granted locally and answered with err_o=1.
// -----------------------------------------------------------------------------
module brq_lsu_tlul_host
    import tlul_pkg::*;
#(
    parameter int MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i
);

    localparam int CntW = brq_cnt_w(MaxOutstanding);
    localparam int PtrW = brq_ptr_w(MaxOutstanding);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [PtrW-1:0]           src_wr_q, src_wr_d;
    logic [PtrW-1:0]           src_rd_q, src_rd_d;
    logic [MaxOutstanding-1:0] is_store_q, is_store_d;
    logic                      rvalid_q, rvalid_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;

    logic a_valid_s;
    logic a_hs_s;
    logic d_hs_s;
    logic mis_gnt_s;

    // Response fields the bridge does not inspect (opcode is deliberately unchecked).
    logic unused_tl_s;
    assign unused_tl_s = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                           tl_i.d_sink, tl_i.d_user};

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    function automatic tl_a_op_e a_opcode_f(input logic we, input logic [3:0] be);
        if (!we) begin
            return Get;
        end else if (be == 4'hF) begin
            return PutFullData;
        end else begin
            return PutPartialData;
        end
    endfunction

    // Request qualification, handshakes and grant.
    always_comb begin
`ifdef BRQ_TLUL_MISALIGN_ERR_EN
        logic misalign_s;
        misalign_s = (addr_i[1:0] != 2'b00);
        a_valid_s  = !rst_i && req_i && (cnt_q < CntMax) && !misalign_s;
        // Misaligned requests are only answered once nothing is in flight,
        // so the local error response cannot overtake a bus response.
        mis_gnt_s  = !rst_i && req_i && misalign_s && (cnt_q == '0);
`else
        a_valid_s  = !rst_i && req_i && (cnt_q < CntMax);
        mis_gnt_s  = 1'b0;
`endif
        a_hs_s = a_valid_s && tl_i.a_ready;
        // d_ready is tied high; a beat with nothing outstanding is ignored.
        d_hs_s = !rst_i && tl_i.d_valid && (cnt_q != '0);
        gnt_o  = a_hs_s || mis_gnt_s;
    end

    // A-channel assembly.
    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid_s;
        tl_o.a_opcode  = a_opcode_f(we_i, be_i);
        tl_o.a_param   = 3'd0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = TL_AIW'(src_wr_q);
        tl_o.a_address = addr_i;
        tl_o.a_mask    = be_i;
        tl_o.a_data    = wdata_i;
        tl_o.a_user    = '0;
        tl_o.d_ready   = 1'b1;
    end

    // Outstanding count, pointers and per-source store flags.
    always_comb begin
        cnt_d      = cnt_q;
        src_wr_d   = src_wr_q;
        src_rd_d   = src_rd_q;
        is_store_d = is_store_q;
        if (a_hs_s && !d_hs_s) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!a_hs_s && d_hs_s) begin
            cnt_d = cnt_q - CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (a_hs_s) begin
            src_wr_d               = ptr_inc(src_wr_q);
            is_store_d[src_wr_q]   = we_i;
        end else begin
            src_wr_d = src_wr_q;
        end
        if (d_hs_s) begin
            src_rd_d = ptr_inc(src_rd_q);
        end else begin
            src_rd_d = src_rd_q;
        end
    end

    // Response stage: in-order source check, store data forced to zero.
    always_comb begin
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (d_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = is_store_q[src_rd_q] ? 32'h0 : tl_i.d_data;
            err_d    = tl_i.d_error || (tl_i.d_source != TL_AIW'(src_rd_q));
        end else if (mis_gnt_s) begin
            rvalid_d = 1'b1;
            rdata_d  = 32'h0;
            err_d    = 1'b1;
        end else begin
            rvalid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            src_wr_q   <= '0;
            src_rd_q   <= '0;
            is_store_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            src_wr_q   <= src_wr_d;
            src_rd_q   <= src_rd_d;
            is_store_q <= is_store_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule
